// File: rtl/pipe_skid_reg.sv
// Elastic pipeline-stage register with a one-entry skid buffer, synchronous flush
// and a saturating stall-cycle counter. All outputs come straight from flops.
module pipe_skid_reg #(
    parameter int DATA_W = 96,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] skid_data;
    logic              in_fire;
    logic              out_fire;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    // in_ready and out_valid are kept as their own flops, updated alongside state,
    // so neither output is decoded combinationally from the state encoding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            out_data  <= '0;
            skid_data <= '0;
            stall_cnt <= '0;
        end else begin
            if (out_valid && !out_ready)
                stall_cnt <= sat_inc(stall_cnt);

            if (flush) begin
                state     <= EMPTY;
                out_valid <= 1'b0;
                in_ready  <= 1'b1;
                out_data  <= '0;
                skid_data <= '0;
            end else begin
                unique case (state)
                    EMPTY: begin
                        if (in_fire) begin
                            out_data  <= in_data;
                            state     <= BUSY;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b1;
                        end
                    end
                    BUSY: begin
                        if (in_fire && out_fire) begin
                            out_data <= in_data;
                        end else if (in_fire) begin
                            skid_data <= in_data;
                            state     <= FULL;
                            in_ready  <= 1'b0;
                        end else if (out_fire) begin
                            // main keeps the departed word; only validity drops
                            state     <= EMPTY;
                            out_valid <= 1'b0;
                        end
                    end
                    FULL: begin
                        if (out_fire) begin
                            out_data <= skid_data;
                            state    <= BUSY;
                            in_ready <= 1'b1;
                        end
                    end
                    default: begin
                        state     <= EMPTY;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: directed scenarios then random traffic, all checked
// against a 2-entry FIFO model with a saturating stall counter.
module tb_pipe_skid_reg;

    localparam int DATA_W = 16;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] q[$];
    logic [DATA_W-1:0] shadow;
    int                m_stall;

    pipe_skid_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        shadow  = '0;
        m_stall = 0;
    endtask

    // Entered at posedge+1: drive, compare registered outputs, clock, update model.
    task automatic cycle(input logic iv, input logic [DATA_W-1:0] d,
                         input logic ordy, input logic fl);
        logic mi_fire, mo_fire;
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        #1;
        chk("out_valid", 32'(out_valid), 32'(q.size() > 0));
        chk("in_ready",  32'(in_ready),  32'(q.size() < 2));
        chk("out_data",  32'(out_data),  32'(shadow));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        mi_fire = iv && (q.size() < 2);
        mo_fire = (q.size() > 0) && ordy;
        if ((q.size() > 0) && !ordy && m_stall < CMAX) m_stall++;
        @(posedge clk);
        #1;
        if (fl) begin
            q.delete();
            shadow = '0;
        end else begin
            if (mo_fire) void'(q.pop_front());
            if (mi_fire) q.push_back(d);
        end
        if (q.size() > 0) shadow = q[0];
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        rst_n = 1'b1;

        // reset/stream: 1,2,3 back to back
        cycle(1'b1, 16'h1, 1'b1, 1'b0);
        chk("stream_1", 32'(out_data), 32'h1);
        cycle(1'b1, 16'h2, 1'b1, 1'b0);
        chk("stream_2", 32'(out_data), 32'h2);
        cycle(1'b1, 16'h3, 1'b1, 1'b0);
        chk("stream_3", 32'(out_data), 32'h3);
        chk("stream_v", 32'(out_valid), 32'd1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("stream_stall", 32'(stall_cnt), 32'd0);

        // stall with skid
        cycle(1'b1, 16'hA, 1'b1, 1'b0);
        cycle(1'b1, 16'hB, 1'b0, 1'b0);
        chk("skid_in_ready", 32'(in_ready), 32'd0);
        cycle(1'b1, 16'hC, 1'b0, 1'b0);
        chk("skid_hold_a", 32'(out_data), 32'hA);
        cycle(1'b1, 16'hC, 1'b1, 1'b0);
        chk("skid_b", 32'(out_data), 32'hB);
        cycle(1'b1, 16'hC, 1'b1, 1'b0);
        chk("skid_c", 32'(out_data), 32'hC);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);
        chk("skid_drained", 32'(out_valid), 32'd0);

        // flush while FULL, with a word offered in the same cycle
        cycle(1'b1, 16'hA, 1'b0, 1'b0);
        cycle(1'b1, 16'hB, 1'b0, 1'b0);
        cycle(1'b1, 16'hD, 1'b0, 1'b1);
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_out_data",  32'(out_data),  32'd0);
        chk("flush_in_ready",  32'(in_ready),  32'd1);
        cycle(1'b0, 16'h0, 1'b1, 1'b0);

        // stall counter saturation; flush leaves it alone
        cycle(1'b1, 16'h5, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 16'h0, 1'b0, 1'b0);
        chk("sat_15", 32'(stall_cnt), 32'd15);
        cycle(1'b0, 16'h0, 1'b0, 1'b1);
        chk("sat_after_flush", 32'(stall_cnt), 32'd15);

        // async reset between edges while FULL
        cycle(1'b1, 16'h1, 1'b0, 1'b0);
        cycle(1'b1, 16'h2, 1'b0, 1'b0);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("areset_out_valid", 32'(out_valid), 32'd0);
        chk("areset_in_ready",  32'(in_ready),  32'd1);
        chk("areset_out_data",  32'(out_data),  32'd0);
        chk("areset_stall_cnt", 32'(stall_cnt), 32'd0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // random traffic
        for (int i = 0; i < 10000; i++) begin
            logic iv, ordy, fl;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = (i % 400 < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fl   = ($urandom_range(0, 63) == 0);
            cycle(iv, DATA_W'($urandom), ordy, fl);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_skid_reg.md
# pipe_skid_reg

Parametrised elastic pipeline-stage register: the successor to the fixed-width stall/clear stage registers between the CPU pipeline stages. Carries a DATA_W-bit payload with a valid/ready handshake and a one-entry skid buffer, so stalls propagate without a combinational path from `out_ready` to `in_ready`. Supports synchronous flush to bubble and a saturating stall-cycle counter for performance analysis. Instances sit between IF/ID, ID/EX, EX/MEM and MEM/WB, with stage fields concatenated into `in_data`.

## Interface
- `DATA_W`, 96: payload width in bits, ≥1 (e.g. instr+PC+PC+4 = 96).
- `CNT_W`, 16: stall counter width in bits, ≥1.

- `clk`  in  1  clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous flush: empty the stage, zero payloads.
- `in_valid`  in  1  upstream has a word on `in_data`.
- `in_ready`  out  1  stage can accept; registered (depends on state only).
- `in_data`  in  DATA_W  upstream payload.
- `out_valid`  out  1  `out_data` holds a valid word.
- `out_ready`  in  1  downstream accepts this cycle.
- `out_data`  out  DATA_W  payload to downstream; zero when stage empty after reset/flush.
- `stall_cnt`  out  CNT_W  cycles with `out_valid && !out_ready`, saturating.

## Operation
- Storage: main register (drives `out_data`) and skid register, each DATA_W bits.
- Fire definitions: in_fire = `in_valid && in_ready`; out_fire = `out_valid && out_ready`.
- States (2-bit encoded):
  - EMPTY: main and skid invalid; `out_valid`=0, `in_ready`=1.
  - BUSY: main valid, skid invalid; `out_valid`=1, `in_ready`=1.
  - FULL: both valid; `out_valid`=1, `in_ready`=0.
- Transitions (when `flush`=0):
  - EMPTY: in_fire → main<=in_data, BUSY; else stay.
  - BUSY: in_fire & out_fire → main<=in_data, stay BUSY; in_fire & !out_fire → skid<=in_data, FULL; !in_fire & out_fire → EMPTY (main keeps stale data); else stay.
  - FULL: out_fire → main<=skid, BUSY; else hold. No input accepted.
- Order: words leave in acceptance order; none duplicated or dropped except by flush.
- Flush: highest priority. Next state EMPTY, main and skid cleared to 0. Any in_fire in the flush cycle is discarded; downstream must not treat `out_fire` in the flush cycle specially (it completes normally).
- `stall_cnt`: +1 each cycle `out_valid && !out_ready`; holds at 2^CNT_W−1. Unaffected by `flush`; cleared only by reset.

## Timing
- Reset (`rst_n`=0, async): state EMPTY, `out_valid`=0, `in_ready`=1, `out_data`=0, skid=0, `stall_cnt`=0. Reset mid-transfer discards both entries. Deassertion is taken synchronously by the surrounding reset synchroniser.
- Latency: word accepted at edge N appears on `out_data` with `out_valid`=1 after edge N (1 cycle).
- Throughput: one word per cycle sustained while `out_ready`=1.
- `in_ready` falls the cycle after a stall begins with BUSY; exactly one extra word is absorbed by the skid register.
- `in_ready` rises one cycle after FULL→BUSY; no combinational path `out_ready`→`in_ready`.
- `out_valid`, `out_data`, `in_ready`, `stall_cnt` are all direct register outputs.

## Test plan
- Reset/stream: `rst_n` low then high, `out_ready`=1, push 0x1,0x2,0x3 on consecutive cycles → `out_data` 0x1,0x2,0x3 on the following three cycles, `out_valid`=1 each, `stall_cnt`=0.
- Stall with skid: BUSY holding 0xA, `out_ready`=0, push 0xB → FULL, `in_ready`=0 next cycle, 0xC held upstream; release `out_ready` → 0xA, 0xB, 0xC out in order, nothing lost.
- Flush in FULL: FULL with 0xA/0xB, assert `flush` with `in_valid`=1, `in_data`=0xD → next cycle EMPTY, `out_valid`=0, `out_data`=0, `in_ready`=1; 0xD never appears.
- Stall counter saturation: CNT_W=4, hold `out_valid`=1, `out_ready`=0 for 20 cycles → `stall_cnt` reaches 15 and stays 15; flush does not clear it.
- Async reset mid-operation: assert `rst_n`=0 between edges while FULL → `out_valid`=0, `in_ready`=1, `out_data`=0 immediately, without a clock edge.
- Random: constrained-random `in_valid`/`out_ready`/`flush` for 10k cycles against a 2-entry FIFO scoreboard → order and contents match; `in_ready`=0 only in FULL.
